// File: rtl/stage6_basic_operation_if.sv
// Control and observation bundle between the stack-CPU controller and the
// stage-6 datapath; the controller is the master.
interface stage6_basic_operation_if;
   logic        PCWrite;
   logic        PCSource;
   logic        PCAdd;
   logic        IRWrite;
   logic        ValAWrite;
   logic        ValBWrite;
   logic        ResWrite;
   logic        MSPWrite;
   logic        MSPop;
   logic        RSPWrite;
   logic        RSPop;
   logic        MemRead1;
   logic        MemWrite1;
   logic        MemRead2;
   logic        MemWrite2;
   logic [1:0]  MemDst1;
   logic [1:0]  MemDst2;
   logic [2:0]  MemData;
   logic [15:0] SignExtOut;
   logic [15:0] ZeroExtOut;
   logic [15:0] ShifterOut;
   logic        ResSource;
   logic [3:0]  ALUop;
   logic [15:0] PCOut;
   logic [15:0] IROut;
   logic [15:0] ValAOut;
   logic [15:0] ValBOut;
   logic [15:0] MSPOut;
   logic [15:0] RSPOut;
   logic        isZero;

   modport master (
      output PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite, ResWrite,
             MSPWrite, MSPop, RSPWrite, RSPop, MemRead1, MemWrite1, MemRead2,
             MemWrite2, MemDst1, MemDst2, MemData, SignExtOut, ZeroExtOut,
             ShifterOut, ResSource, ALUop,
      input  PCOut, IROut, ValAOut, ValBOut, MSPOut, RSPOut, isZero
   );

   modport slave (
      input  PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite, ResWrite,
             MSPWrite, MSPop, RSPWrite, RSPop, MemRead1, MemWrite1, MemRead2,
             MemWrite2, MemDst1, MemDst2, MemData, SignExtOut, ZeroExtOut,
             ShifterOut, ResSource, ALUop,
      output PCOut, IROut, ValAOut, ValBOut, MSPOut, RSPOut, isZero
   );
endinterface

// File: rtl/stage6_basic_operation.sv
// Stage-6 stack-CPU datapath: PC, IR, operand/result registers, two stack
// pointers, ALU and a dual-port 1K x 16 word memory, all sequenced externally.
module stage6_basic_operation (
   input logic                     clk,
   input logic                     rst,
   stage6_basic_operation_if.slave bus
);
   localparam logic [15:0] RSP_RESET = 16'h0300;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
      ALU_XOR = 4'd4, ALU_NOT = 4'd5, ALU_SLT = 4'd6, ALU_PASSA = 4'd7,
      ALU_PASSB = 4'd8
   } alu_op_e;

   function automatic logic [1023:0][15:0] init_image();
      logic [1023:0][15:0] img;
      for (int i = 0; i < 1024; i++) img[i] = 16'(i % 10);
      return img;
   endfunction

   // Contents survive reset; the image below is the power-up state.
   logic [1023:0][15:0] mem = init_image();

   logic [15:0] pc_q, pc_d, ir_q, ir_d, val_a_q, val_a_d, val_b_q, val_b_d;
   logic [15:0] res_q, res_d, mdr1_q, mdr1_d, mdr2_q, mdr2_d;
   logic [15:0] msp_q, msp_d, rsp_q, rsp_d;
   logic [9:0]  addr1, addr2;
   logic [15:0] wdata1, alu_y;

   always_comb begin
      addr1 = pc_q[9:0];
      case (bus.MemDst1)
         2'b00:   addr1 = pc_q[9:0];
         2'b01:   addr1 = msp_q[9:0];
         2'b10:   addr1 = val_a_q[9:0];
         default: addr1 = rsp_q[9:0];
      endcase
      addr2 = msp_q[9:0];
      case (bus.MemDst2)
         2'b00:   addr2 = msp_q[9:0];
         2'b01:   addr2 = rsp_q[9:0];
         2'b10:   addr2 = val_b_q[9:0];
         default: addr2 = res_q[9:0];
      endcase
      wdata1 = val_a_q;
      case (bus.MemData)
         3'd0:    wdata1 = val_a_q;
         3'd1:    wdata1 = val_b_q;
         3'd2:    wdata1 = res_q;
         3'd3:    wdata1 = pc_q;
         3'd4:    wdata1 = bus.SignExtOut;
         3'd5:    wdata1 = bus.ZeroExtOut;
         3'd6:    wdata1 = bus.ShifterOut;
         default: wdata1 = ir_q;
      endcase
   end

   always_comb begin
      alu_y = 16'h0000;
      case (alu_op_e'(bus.ALUop))
         ALU_ADD:   alu_y = val_a_q + val_b_q;
         ALU_SUB:   alu_y = val_a_q - val_b_q;
         ALU_AND:   alu_y = val_a_q & val_b_q;
         ALU_OR:    alu_y = val_a_q | val_b_q;
         ALU_XOR:   alu_y = val_a_q ^ val_b_q;
         ALU_NOT:   alu_y = ~val_a_q;
         ALU_SLT:   alu_y = {15'd0, $signed(val_a_q) < $signed(val_b_q)};
         ALU_PASSA: alu_y = val_a_q;
         ALU_PASSB: alu_y = val_b_q;
         default:   alu_y = 16'h0000;
      endcase
   end

   // Every load samples pre-edge values, so MDRs feed registers one edge later.
   always_comb begin
      pc_d = pc_q;
      if (bus.PCWrite) begin
         if (bus.PCSource)   pc_d = val_a_q;
         else if (bus.PCAdd) pc_d = pc_q + bus.SignExtOut;
         else                pc_d = pc_q + 16'd1;
      end
      msp_d = msp_q;
      if (bus.MSPWrite) msp_d = bus.MSPop ? msp_q - 16'd1 : msp_q + 16'd1;
      rsp_d = rsp_q;
      if (bus.RSPWrite) rsp_d = bus.RSPop ? rsp_q + 16'd1 : rsp_q - 16'd1;
      mdr1_d  = bus.MemRead1  ? mem[addr1] : mdr1_q;
      mdr2_d  = bus.MemRead2  ? mem[addr2] : mdr2_q;
      ir_d    = bus.IRWrite   ? mdr1_q : ir_q;
      val_b_d = bus.ValBWrite ? mdr1_q : val_b_q;
      val_a_d = bus.ValAWrite ? mdr2_q : val_a_q;
      res_d   = res_q;
      if (bus.ResWrite) res_d = bus.ResSource ? bus.ShifterOut : alu_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= 16'h0000;
         ir_q    <= 16'h0000;
         val_a_q <= 16'h0000;
         val_b_q <= 16'h0000;
         res_q   <= 16'h0000;
         mdr1_q  <= 16'h0000;
         mdr2_q  <= 16'h0000;
         msp_q   <= 16'h0000;
         rsp_q   <= RSP_RESET;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         val_a_q <= val_a_d;
         val_b_q <= val_b_d;
         res_q   <= res_d;
         mdr1_q  <= mdr1_d;
         mdr2_q  <= mdr2_d;
         msp_q   <= msp_d;
         rsp_q   <= rsp_d;
      end
   end

   // Port 2 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (bus.MemWrite1) mem[addr1] <= wdata1;
      if (bus.MemWrite2) mem[addr2] <= val_b_q;
   end

   assign bus.PCOut   = pc_q;
   assign bus.IROut   = ir_q;
   assign bus.ValAOut = val_a_q;
   assign bus.ValBOut = val_b_q;
   assign bus.MSPOut  = msp_q;
   assign bus.RSPOut  = rsp_q;
   assign bus.isZero  = (alu_y == 16'h0000);
endmodule

// File: tb/tb_stage6_basic_operation.sv
// Bench for the stage-6 datapath: directed test-plan scenarios plus random
// control sequences checked against a word-level model of the datapath.
module tb_stage6_basic_operation;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stage6_basic_operation_if bus ();
   stage6_basic_operation dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic pc_write, pc_source, pc_add, ir_write, vala_write, valb_write;
      logic res_write, msp_write, msp_pop, rsp_write, rsp_pop;
      logic rd1, wr1, rd2, wr2;
      logic [1:0] dst1, dst2;
      logic [2:0] mdata;
      logic res_src;
      logic [3:0] op;
      logic [15:0] sext, zext, shft;
   } ctrl_t;

   int checks = 0;
   int errors = 0;
   string rname [6] = '{"PC", "IR", "ValA", "ValB", "MSP", "RSP"};

   logic [15:0] m_mem [1024];
   logic [15:0] m_pc, m_ir, m_a, m_b, m_res, m_mdr1, m_mdr2, m_msp, m_rsp;
   logic [15:0] got [6];
   logic [15:0] exp [6];

   function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ~a;
         4'd6: return (sa < sb) ? 16'd1 : 16'd0;
         4'd7: return a;
         4'd8: return b;
         default: return 16'd0;
      endcase
   endfunction

   task automatic model_reset();
      {m_pc, m_ir, m_a, m_b, m_res, m_mdr1, m_mdr2, m_msp} = '0;
      m_rsp = 16'h0300;
   endtask

   task automatic drive(input ctrl_t c);
      bus.PCWrite = c.pc_write;     bus.PCSource = c.pc_source; bus.PCAdd = c.pc_add;
      bus.IRWrite = c.ir_write;     bus.ValAWrite = c.vala_write; bus.ValBWrite = c.valb_write;
      bus.ResWrite = c.res_write;   bus.MSPWrite = c.msp_write; bus.MSPop = c.msp_pop;
      bus.RSPWrite = c.rsp_write;   bus.RSPop = c.rsp_pop;
      bus.MemRead1 = c.rd1;         bus.MemWrite1 = c.wr1;
      bus.MemRead2 = c.rd2;         bus.MemWrite2 = c.wr2;
      bus.MemDst1 = c.dst1;         bus.MemDst2 = c.dst2;       bus.MemData = c.mdata;
      bus.ResSource = c.res_src;    bus.ALUop = c.op;
      bus.SignExtOut = c.sext;      bus.ZeroExtOut = c.zext;    bus.ShifterOut = c.shft;
   endtask

   // One clock with controls c applied; the model advances alongside.
   task automatic step(input ctrl_t c);
      int a1, a2;
      logic [15:0] d1, n_pc, n_ir, n_a, n_b, n_res, n_mdr1, n_mdr2, n_msp, n_rsp;
      drive(c);
      case (c.dst1)
         2'd0: a1 = int'(m_pc) % 1024;
         2'd1: a1 = int'(m_msp) % 1024;
         2'd2: a1 = int'(m_a) % 1024;
         default: a1 = int'(m_rsp) % 1024;
      endcase
      case (c.dst2)
         2'd0: a2 = int'(m_msp) % 1024;
         2'd1: a2 = int'(m_rsp) % 1024;
         2'd2: a2 = int'(m_b) % 1024;
         default: a2 = int'(m_res) % 1024;
      endcase
      case (c.mdata)
         3'd0: d1 = m_a;   3'd1: d1 = m_b;   3'd2: d1 = m_res;  3'd3: d1 = m_pc;
         3'd4: d1 = c.sext; 3'd5: d1 = c.zext; 3'd6: d1 = c.shft; default: d1 = m_ir;
      endcase
      n_pc = m_pc;
      if (c.pc_write) n_pc = c.pc_source ? m_a : (c.pc_add ? m_pc + c.sext : m_pc + 16'd1);
      n_msp = c.msp_write ? (c.msp_pop ? m_msp - 16'd1 : m_msp + 16'd1) : m_msp;
      n_rsp = c.rsp_write ? (c.rsp_pop ? m_rsp + 16'd1 : m_rsp - 16'd1) : m_rsp;
      n_mdr1 = c.rd1 ? m_mem[a1] : m_mdr1;
      n_mdr2 = c.rd2 ? m_mem[a2] : m_mdr2;
      n_ir  = c.ir_write   ? m_mdr1 : m_ir;
      n_b   = c.valb_write ? m_mdr1 : m_b;
      n_a   = c.vala_write ? m_mdr2 : m_a;
      n_res = c.res_write  ? (c.res_src ? c.shft : ref_alu(c.op, m_a, m_b)) : m_res;
      @(posedge clk);
      if (c.wr1) m_mem[a1] = d1;
      if (c.wr2) m_mem[a2] = m_b;
      {m_pc, m_ir, m_a, m_b, m_res, m_mdr1, m_mdr2, m_msp, m_rsp} =
         {n_pc, n_ir, n_a, n_b, n_res, n_mdr1, n_mdr2, n_msp, n_rsp};
      #1;
   endtask

   task automatic test_reset();
      ctrl_t c;
      c = '0;
      drive(c);
      rst = 1'b1;
      model_reset();
      #12 rst = 1'b0;
      #1;
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0300};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL reset_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
      checks++;
      if (bus.isZero !== 1'b1) begin errors++; $display("FAIL reset_isZero got %b want 1", bus.isZero); end
      c.msp_write = 1'b1;
      for (int i = 0; i < 54; i++) step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0036, 16'h0300};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL push54_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_fetch();
      ctrl_t c;
      c = '0; c.pc_write = 1; c.pc_add = 1; c.sext = 16'd5;
      step(c);
      c = '0; c.pc_write = 1; c.rd1 = 1; c.rd2 = 1; c.msp_write = 1; c.msp_pop = 1;
      step(c);
      c = '0; c.ir_write = 1; c.vala_write = 1;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h6, 16'h5, 16'h4, 16'h0, 16'h0035, 16'h0300};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL fetch_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_load_valb();
      ctrl_t c;
      c = '0; c.msp_write = 1; c.msp_pop = 1;
      for (int i = 0; i < 21; i++) step(c);
      c = '0; c.rd1 = 1; c.dst1 = 2'b01; c.msp_write = 1;
      step(c);
      c = '0; c.valb_write = 1;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h6, 16'h5, 16'h4, 16'h2, 16'h0021, 16'h0300};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL loadvalb_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_return_stack();
      ctrl_t c;
      c = '0; c.rd2 = 1; c.dst2 = 2'b01; c.rsp_write = 1; c.rsp_pop = 1;
      step(c);
      c = '0; c.vala_write = 1;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h6, 16'h5, 16'h8, 16'h2, 16'h0021, 16'h0301};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL rstack_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_jpop();
      ctrl_t c;
      c = '0; c.msp_write = 1; c.msp_pop = 1;
      for (int i = 0; i < 26; i++) step(c);
      c = '0; c.rd2 = 1;
      step(c);
      c = '0; c.vala_write = 1;
      step(c);
      checks++;
      if (bus.ValAOut !== 16'h7) begin errors++; $display("FAIL jpop_setup_ValA got %h want %h", bus.ValAOut, 16'h7); end
      c = '0; c.msp_write = 1;
      for (int i = 0; i < 11; i++) step(c);
      c = '0; c.pc_write = 1; c.pc_source = 1; c.rd2 = 1; c.msp_write = 1; c.msp_pop = 1;
      step(c);
      c = '0; c.vala_write = 1;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h7, 16'h5, 16'h8, 16'h2, 16'h0011, 16'h0301};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL jpop_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_pc_add();
      ctrl_t c;
      c = '0; c.pc_write = 1; c.pc_add = 1; c.sext = 16'h0039;
      step(c);
      c.sext = 16'h000D;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h004D, 16'h5, 16'h8, 16'h2, 16'h0011, 16'h0301};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL pcadd_fwd_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
      c.sext = 16'hFFF3;
      step(c);
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h0040, 16'h5, 16'h8, 16'h2, 16'h0011, 16'h0301};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL pcadd_back_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
   endtask

   task automatic test_mem_write();
      ctrl_t c;
      // Both ports hit mem[0x11] (holds 7) while port 1 also reads it.
      c = '0; c.wr1 = 1; c.dst1 = 2'b01; c.mdata = 3'd4; c.sext = 16'hAAAA;
      c.wr2 = 1; c.dst2 = 2'b00; c.rd1 = 1;
      step(c);
      c = '0; c.ir_write = 1; c.rd1 = 1; c.dst1 = 2'b01;
      step(c);
      checks++;
      if (bus.IROut !== 16'h7) begin errors++; $display("FAIL rdw_old_data got %h want %h", bus.IROut, 16'h7); end
      c = '0; c.ir_write = 1;
      step(c);
      checks++;
      if (bus.IROut !== 16'h2) begin errors++; $display("FAIL port2_wins got %h want %h", bus.IROut, 16'h2); end
      c = '0; c.wr1 = 1; c.dst1 = 2'b10; c.mdata = 3'd5; c.zext = 16'h1234;
      step(c);
      c = '0; c.rd1 = 1; c.dst1 = 2'b10;
      step(c);
      c = '0; c.ir_write = 1;
      step(c);
      checks++;
      if (bus.IROut !== 16'h1234) begin errors++; $display("FAIL port1_write got %h want %h", bus.IROut, 16'h1234); end
   endtask

   task automatic test_reset_mid();
      ctrl_t c;
      c = '0; c.rd1 = 1; c.rd2 = 1;
      step(c);
      c = '0; c.ir_write = 1; c.vala_write = 1;
      drive(c);
      #2 rst = 1'b1;
      model_reset();
      #1;
      got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
      exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0300};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL midreset_%s got %h want %h", rname[i], got[i], exp[i]); end
      end
      #1 rst = 1'b0;
      step(c);
      checks++;
      if (bus.IROut !== 16'h0 || bus.ValAOut !== 16'h0) begin
         errors++;
         $display("FAIL mdr_discard got IR %h ValA %h want 0000 0000", bus.IROut, bus.ValAOut);
      end
   endtask

   task automatic test_random();
      ctrl_t c;
      logic [95:0] r;
      logic zexp;
      for (int n = 0; n < 600; n++) begin
         r = {$urandom(), $urandom(), $urandom()};
         c = ctrl_t'(r[$bits(ctrl_t)-1:0]);
         step(c);
         got = '{bus.PCOut, bus.IROut, bus.ValAOut, bus.ValBOut, bus.MSPOut, bus.RSPOut};
         exp = '{m_pc, m_ir, m_a, m_b, m_msp, m_rsp};
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_%s got %h want %h", n, rname[i], got[i], exp[i]); end
         end
         zexp = (ref_alu(c.op, m_a, m_b) == 16'h0000);
         checks++;
         if (bus.isZero !== zexp) begin errors++; $display("FAIL rand%0d_isZero op %0d got %b want %b", n, c.op, bus.isZero, zexp); end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) m_mem[i] = 16'(i % 10);
      test_reset();
      test_fetch();
      test_load_valb();
      test_return_stack();
      test_jpop();
      test_pc_add();
      test_mem_write();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout simulation exceeded 500000 time units");
      $fatal(1, "[TB] timeout");
   end
endmodule
